// File: rtl/uart_rx_framed.sv
// uart_rx_framed: 8N1 UART receiver, LSB first, with a one-deep holding
// register (valid/ready), start-glitch rejection, framing error detection
// and a sticky overrun flag.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit (8E1/8O1)
// selected by PARITY_ODD; without it Parity_Err is tied low.
module uart_rx_framed #(
  parameter int unsigned CLKS_PER_BIT = 2000000,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx_Serial,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Valid,
  input  logic       Rx_Ready,
  output logic       Rx_Busy,
  output logic       Frame_Err,
  output logic       Parity_Err,
  output logic       Overrun,
  input  logic       Overrun_Clr
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic [1:0]       sync_q;
  logic             rxs;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
`endif
  logic             cnt_last_c;
  logic             deliver_c;
  logic             frame_err_c;
  logic             parity_err_c;
  logic             pop_c;

  assign rxs        = sync_q[1];
  assign cnt_last_c = (clk_cnt_q == CNT_LAST);
  assign pop_c      = Rx_Valid & Rx_Ready;

  // State register, synchroniser and receive datapath
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q    <= 2'b11;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], Rx_Serial};
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state logic: bit timing, sampling and frame verdict
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
`endif
    deliver_c    = 1'b0;
    frame_err_c  = 1'b0;
    parity_err_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rxs) state_d = S_START;
      end

      S_START: begin
        if (clk_cnt_q == CNT_MID) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
          // A start bit that is high again at mid-bit was only a glitch
          state_d   = rxs ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_last_c) begin
          clk_cnt_d = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_last_c) begin
          clk_cnt_d = '0;
          par_bad_d = rxs != ((^shift_q) ^ PARITY_ODD);
          state_d   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (cnt_last_c) begin
          clk_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_c = par_bad_q;
          deliver_c    = rxs & ~par_bad_q;
`else
          deliver_c    = rxs;
`endif
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            frame_err_c = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end
      end

      // Hold off until the line goes high so a break is not seen as frames
      S_WAIT_IDLE: begin
        clk_cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end

      default: begin
        clk_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Holding register, handshake, status flags
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Rx_Byte    <= '0;
      Rx_Valid   <= 1'b0;
      Rx_Busy    <= 1'b0;
      Frame_Err  <= 1'b0;
      Parity_Err <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      Rx_Busy    <= (state_d != S_IDLE);
      Frame_Err  <= frame_err_c;
      Parity_Err <= parity_err_c;

      if (deliver_c && (!Rx_Valid || pop_c)) begin
        Rx_Byte  <= shift_q;
        Rx_Valid <= 1'b1;
      end else if (pop_c) begin
        Rx_Valid <= 1'b0;
      end

      if (Overrun_Clr) begin
        Overrun <= 1'b0;
      end else if (deliver_c && Rx_Valid && !pop_c) begin
        Overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Self-checking bench for uart_rx_framed: directed scenarios followed by
// random frames, compared against a frame-level model of the receiver.
module tb_uart_rx_framed;

  localparam int unsigned C = 8;
  localparam int unsigned H = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR_EN = 1'b1;
  localparam int unsigned NB     = 10;
`else
  localparam bit          PAR_EN = 1'b0;
  localparam int unsigned NB     = 9;
`endif
  // Pin-level start edge to Rx_Valid rise, including the synchroniser
  localparam int unsigned LAT = H + 1 + NB * C + 1 + 2;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Rx_Serial;
  logic [7:0] Rx_Byte;
  logic       Rx_Valid;
  logic       Rx_Ready;
  logic       Rx_Busy;
  logic       Frame_Err;
  logic       Parity_Err;
  logic       Overrun;
  logic       Overrun_Clr;

  uart_rx_framed #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Rx_Serial   (Rx_Serial),
    .Rx_Byte     (Rx_Byte),
    .Rx_Valid    (Rx_Valid),
    .Rx_Ready    (Rx_Ready),
    .Rx_Busy     (Rx_Busy),
    .Frame_Err   (Frame_Err),
    .Parity_Err  (Parity_Err),
    .Overrun     (Overrun),
    .Overrun_Clr (Overrun_Clr)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  int   valid_cycles = 0;
  int   fe_cnt = 0;
  int   pe_cnt = 0;
  logic prev_valid = 1'b0;
  always @(negedge Clk) begin
    if (Rx_Valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    if (Rx_Valid === 1'b1) valid_cycles = valid_cycles + 1;
    if (Frame_Err === 1'b1) fe_cnt = fe_cnt + 1;
    if (Parity_Err === 1'b1) pe_cnt = pe_cnt + 1;
    prev_valid = Rx_Valid;
  end

  int checks = 0;
  int errors = 0;

  // Reference model of the holding register
  logic       m_valid;
  logic [7:0] m_byte;
  logic       m_overrun;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    Rx_Serial = v;
    tick(n);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byte"}, 32'(Rx_Byte), 32'h0);
    chk({tag, "_valid"}, 32'(Rx_Valid), 32'h0);
    chk({tag, "_busy"}, 32'(Rx_Busy), 32'h0);
    chk({tag, "_ferr"}, 32'(Frame_Err), 32'h0);
    chk({tag, "_perr"}, 32'(Parity_Err), 32'h0);
    chk({tag, "_ovr"}, 32'(Overrun), 32'h0);
  endtask

  // Bit-bang one frame; optionally pulse Rx_Ready at the delivery edge
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit par_good,
                            input bit pop_at_load, output int t0);
    logic pbit;
    t0 = cyc;
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) drive(d[i], C);
    if (PAR_EN) begin
      pbit = (^d) ^ ~par_good;
      drive(pbit, C);
    end
    Rx_Serial = stop;
    for (int j = 0; j < int'(C); j++) begin
      if (pop_at_load && j == int'(H) + 3) Rx_Ready = 1'b1;
      if (pop_at_load && j == int'(H) + 4) Rx_Ready = 1'b0;
      tick(1);
    end
  endtask

  // Send a frame, advance the model, compare state and flag pulses
  task automatic run_frame(input string tag, input logic [7:0] d, input logic stop,
                           input bit par_good, input bit pop_at_load,
                           input bit clr_during, input bit keep_low);
    int  r0, f0, p0, t0;
    bit  good, ready_during, exp_rise;
    r0 = rise_cnt; f0 = fe_cnt; p0 = pe_cnt;
    ready_during = (Rx_Ready === 1'b1);
    Overrun_Clr  = clr_during;

    good     = (stop == 1'b1) && (par_good || !PAR_EN);
    exp_rise = 1'b0;
    if (ready_during) m_valid = 1'b0;
    if (good) begin
      if (!m_valid || pop_at_load || ready_during) begin
        exp_rise = !m_valid;
        m_valid  = 1'b1;
        m_byte   = d;
      end else begin
        m_overrun = 1'b1;
      end
    end
    if (ready_during) m_valid = 1'b0;
    if (clr_during) m_overrun = 1'b0;

    send_frame(d, stop, par_good, pop_at_load, t0);
    if (!keep_low) Rx_Serial = 1'b1;
    tick(3);
    Overrun_Clr = 1'b0;

    chk({tag, "_valid"}, 32'(Rx_Valid), 32'(m_valid));
    chk({tag, "_byte"}, 32'(Rx_Byte), 32'(m_byte));
    chk({tag, "_ovr"}, 32'(Overrun), 32'(m_overrun));
    chk({tag, "_ferr_pulses"}, 32'(fe_cnt - f0), 32'(!stop));
    chk({tag, "_perr_pulses"}, 32'(pe_cnt - p0), 32'(PAR_EN && !par_good));
    chk({tag, "_rises"}, 32'(rise_cnt - r0), 32'(exp_rise));
    if (exp_rise) chk({tag, "_latency"}, 32'(rise_cyc - t0), 32'(LAT));
  endtask

  initial begin
    int r0, f0, p0, v0;
    logic [7:0] d;
    logic       stop;
    bit         pg;

    Rst = 1'b1; Rx_Serial = 1'b1; Rx_Ready = 1'b0; Overrun_Clr = 1'b0;
    m_valid = 1'b0; m_byte = 8'h00; m_overrun = 1'b0;
    tick(3);
    Rst = 1'b0;
    tick(2);
    check_reset_values("reset");

    // Basic frame with consumer always ready: one-cycle valid
    Rx_Ready = 1'b1;
    v0 = valid_cycles;
    run_frame("a5", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("a5_valid_cycles", 32'(valid_cycles - v0), 32'd1);

    // Framing error with the line held low afterwards
    run_frame("3c_ferr", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 17);
    chk("break_busy", 32'(Rx_Busy), 32'h1);
    f0 = fe_cnt;
    drive(1'b1, 4);
    chk("break_release_busy", 32'(Rx_Busy), 32'h0);
    chk("break_no_more_ferr", 32'(fe_cnt - f0), 32'h0);
    run_frame("3d", 8'h3D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Short low glitch is rejected
    r0 = rise_cnt; f0 = fe_cnt; p0 = pe_cnt;
    drive(1'b0, 2);
    drive(1'b1, 2);
    chk("glitch_busy_seen", 32'(Rx_Busy), 32'h1);
    tick(C);
    chk("glitch_busy_clear", 32'(Rx_Busy), 32'h0);
    chk("glitch_no_rise", 32'(rise_cnt - r0), 32'h0);
    chk("glitch_no_ferr", 32'(fe_cnt - f0), 32'h0);
    chk("glitch_no_perr", 32'(pe_cnt - p0), 32'h0);

    // Overrun with a stalled consumer
    Rx_Ready = 1'b0;
    run_frame("ovr_11", 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("ovr_22", 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    Rx_Ready = 1'b1; tick(1); Rx_Ready = 1'b0; m_valid = 1'b0;
    tick(1);
    chk("ovr_pop_valid", 32'(Rx_Valid), 32'(m_valid));
    chk("ovr_still_set", 32'(Overrun), 32'(m_overrun));
    Overrun_Clr = 1'b1; tick(1); Overrun_Clr = 1'b0; m_overrun = 1'b0;
    tick(1);
    chk("ovr_cleared", 32'(Overrun), 32'(m_overrun));

    // Load and pop on the same edge, then clear beating a new overrun
    run_frame("hold_44", 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("swap_55", 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame("clrwin_66", 8'h66, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset after three data bits of 0xFF, with a byte still held
    drive(1'b0, C);
    drive(1'b1, 3 * C);
    Rst = 1'b1; tick(1); Rst = 1'b0;
    m_valid = 1'b0; m_byte = 8'h00; m_overrun = 1'b0;
    tick(1);
    check_reset_values("midrst");
    tick(6 * C);
    Rx_Ready = 1'b1;
    run_frame("after_rst_5a", 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    run_frame("par_07_ok", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("par_07_bad", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Random frames: data, stop bit, parity and consumer readiness
    for (int k = 0; k < 16; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      pg   = ($urandom_range(0, 3) != 0);
      Rx_Ready = 1'($urandom_range(0, 1));
      run_frame($sformatf("rnd%0d", k), d, stop, pg, 1'b0, 1'b0, 1'b0);
      tick($urandom_range(2, 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
